// File: rtl/exec_branch_trap_unit_if.sv
// Execute-stage bus bundle for exec_branch_trap_unit.
// Carries the ALU operands and results, branch-resolution signals and the
// ID-stage trace fields. The master drives the inputs and the slave (the unit)
// drives the results.
interface exec_branch_trap_unit_if;
    // ALU / address generation / store formatting
    logic [11:0] op;
    logic        w_check;
    logic        s_check;
    logic [2:0]  s_bhwd;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [63:0] imm;
    logic [63:0] data_rd;
    logic [31:0] ram_raddr;
    logic [63:0] src2_out;
    // Branch resolution
    logic [5:0]  b_check;
    logic [2:0]  pc_sel;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [2:0]  pc_sel_out;
    // Trap / trace tracking
    logic [31:0] id_inst;
    logic [11:0] id_op;
    logic        id_ebreak;
    logic [31:0] inst_out;
    logic [11:0] op_out;
    logic        ebreak_out;

    modport master (
        output op, w_check, s_check, s_bhwd, src1, src2, imm,
        output b_check, pc_sel, rs1_data, rs2_data,
        output id_inst, id_op, id_ebreak,
        input  data_rd, ram_raddr, src2_out, pc_sel_out,
        input  inst_out, op_out, ebreak_out
    );

    modport slave (
        input  op, w_check, s_check, s_bhwd, src1, src2, imm,
        input  b_check, pc_sel, rs1_data, rs2_data,
        input  id_inst, id_op, id_ebreak,
        output data_rd, ram_raddr, src2_out, pc_sel_out,
        output inst_out, op_out, ebreak_out
    );
endinterface

// File: rtl/exec_branch_trap_unit.sv
// Execute-stage slice of the RV64 pipeline: combinational ALU with address
// generation and store-data formatting, combinational branch resolver, and a
// one-stage trap/trace tracker (the only clocked logic).
// Optional feature macro: ALU_MULDIV_EN adds the RV64M ops (codes 13-20);
// without it those codes return 0 and no multiplier/divider exists.
module exec_branch_trap_unit #(
    parameter int XLEN = 64
) (
    input logic                  clk,
    input logic                  rst,
    exec_branch_trap_unit_if.slave bus
);
    localparam logic [11:0] OP_ADD    = 12'd1;
    localparam logic [11:0] OP_SUB    = 12'd2;
    localparam logic [11:0] OP_SLL    = 12'd3;
    localparam logic [11:0] OP_SLT    = 12'd4;
    localparam logic [11:0] OP_SLTU   = 12'd5;
    localparam logic [11:0] OP_XOR    = 12'd6;
    localparam logic [11:0] OP_SRL    = 12'd7;
    localparam logic [11:0] OP_SRA    = 12'd8;
    localparam logic [11:0] OP_OR     = 12'd9;
    localparam logic [11:0] OP_AND    = 12'd10;
    localparam logic [11:0] OP_PASS2  = 12'd11;
    localparam logic [11:0] OP_SNPC   = 12'd12;
`ifdef ALU_MULDIV_EN
    localparam logic [11:0] OP_MUL    = 12'd13;
    localparam logic [11:0] OP_MULH   = 12'd14;
    localparam logic [11:0] OP_MULHSU = 12'd15;
    localparam logic [11:0] OP_MULHU  = 12'd16;
    localparam logic [11:0] OP_DIV    = 12'd17;
    localparam logic [11:0] OP_DIVU   = 12'd18;
    localparam logic [11:0] OP_REM    = 12'd19;
    localparam logic [11:0] OP_REMU   = 12'd20;
`endif

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [31:0]     a32;
    logic [31:0]     b32;
    logic [5:0]      sh64;
    logic [4:0]      sh32;
    logic [XLEN-1:0] sra64;
    logic [31:0]     sra32;
    logic [XLEN-1:0] res64;
    logic [31:0]     res32;

    assign a    = bus.src1;
    assign b    = bus.src2;
    assign a32  = a[31:0];
    assign b32  = b[31:0];
    assign sh64 = b[5:0];
    assign sh32 = b[4:0];
    // Arithmetic shifts kept separate so the signed context is not lost in the mux
    assign sra64 = $signed(a) >>> sh64;
    assign sra32 = $signed(a32) >>> sh32;

`ifdef ALU_MULDIV_EN
    // One unsigned multiplier per width; signed high halves are derived by
    // subtracting the sign corrections from the unsigned high half.
    logic [127:0] prod64;
    logic [63:0]  prod32;
    logic [63:0]  mulh_ss64, mulh_su64;
    logic [31:0]  mulh_ss32, mulh_su32;
    logic         ovf64, ovf32;
    logic [63:0]  q_s64_raw, r_s64_raw, q_s64, r_s64, q_u64, r_u64;
    logic [31:0]  q_s32_raw, r_s32_raw, q_s32, r_s32, q_u32, r_u32;

    assign prod64    = {64'b0, a} * {64'b0, b};
    assign prod32    = {32'b0, a32} * {32'b0, b32};
    assign mulh_su64 = prod64[127:64] - (a[63] ? b : 64'd0);
    assign mulh_ss64 = mulh_su64 - (b[63] ? a : 64'd0);
    assign mulh_su32 = prod32[63:32] - (a32[31] ? b32 : 32'd0);
    assign mulh_ss32 = mulh_su32 - (b32[31] ? a32 : 32'd0);

    // Division corner cases: x/0 gives all ones with remainder x;
    // most-negative / -1 gives the dividend with remainder 0.
    assign ovf64     = (a == 64'h8000_0000_0000_0000) && (b == '1);
    assign ovf32     = (a32 == 32'h8000_0000) && (b32 == '1);
    assign q_s64_raw = $signed(a) / $signed(b);
    assign r_s64_raw = $signed(a) % $signed(b);
    assign q_s32_raw = $signed(a32) / $signed(b32);
    assign r_s32_raw = $signed(a32) % $signed(b32);
    assign q_s64 = (b == 64'd0) ? '1 : (ovf64 ? a : q_s64_raw);
    assign r_s64 = (b == 64'd0) ? a  : (ovf64 ? 64'd0 : r_s64_raw);
    assign q_u64 = (b == 64'd0) ? '1 : a / b;
    assign r_u64 = (b == 64'd0) ? a  : a % b;
    assign q_s32 = (b32 == 32'd0) ? '1  : (ovf32 ? a32 : q_s32_raw);
    assign r_s32 = (b32 == 32'd0) ? a32 : (ovf32 ? 32'd0 : r_s32_raw);
    assign q_u32 = (b32 == 32'd0) ? '1  : a32 / b32;
    assign r_u32 = (b32 == 32'd0) ? a32 : a32 % b32;
`endif

    // Full-width ALU result
    always_comb begin
        res64 = '0;
        case (bus.op)
            OP_ADD:    res64 = a + b;
            OP_SUB:    res64 = a - b;
            OP_SLL:    res64 = a << sh64;
            OP_SLT:    res64 = {63'b0, $signed(a) < $signed(b)};
            OP_SLTU:   res64 = {63'b0, a < b};
            OP_XOR:    res64 = a ^ b;
            OP_SRL:    res64 = a >> sh64;
            OP_SRA:    res64 = sra64;
            OP_OR:     res64 = a | b;
            OP_AND:    res64 = a & b;
            OP_PASS2:  res64 = b;
            OP_SNPC:   res64 = a + 64'd4;
`ifdef ALU_MULDIV_EN
            OP_MUL:    res64 = prod64[63:0];
            OP_MULH:   res64 = mulh_ss64;
            OP_MULHSU: res64 = mulh_su64;
            OP_MULHU:  res64 = prod64[127:64];
            OP_DIV:    res64 = q_s64;
            OP_DIVU:   res64 = q_u64;
            OP_REM:    res64 = r_s64;
            OP_REMU:   res64 = r_u64;
`endif
            default:   res64 = '0;
        endcase
    end

    // 32-bit (*W) ALU result, sign-extended at the output mux
    always_comb begin
        res32 = '0;
        case (bus.op)
            OP_ADD:    res32 = a32 + b32;
            OP_SUB:    res32 = a32 - b32;
            OP_SLL:    res32 = a32 << sh32;
            OP_SLT:    res32 = {31'b0, $signed(a32) < $signed(b32)};
            OP_SLTU:   res32 = {31'b0, a32 < b32};
            OP_XOR:    res32 = a32 ^ b32;
            OP_SRL:    res32 = a32 >> sh32;
            OP_SRA:    res32 = sra32;
            OP_OR:     res32 = a32 | b32;
            OP_AND:    res32 = a32 & b32;
            OP_PASS2:  res32 = b32;
            OP_SNPC:   res32 = a32 + 32'd4;
`ifdef ALU_MULDIV_EN
            OP_MUL:    res32 = prod32[31:0];
            OP_MULH:   res32 = mulh_ss32;
            OP_MULHSU: res32 = mulh_su32;
            OP_MULHU:  res32 = prod32[63:32];
            OP_DIV:    res32 = q_s32;
            OP_DIVU:   res32 = q_u32;
            OP_REM:    res32 = r_s32;
            OP_REMU:   res32 = r_u32;
`endif
            default:   res32 = '0;
        endcase
    end

    assign bus.data_rd   = bus.w_check ? {{32{res32[31]}}, res32} : res64;
    // Only the low 32 address bits reach the data memory
    assign bus.ram_raddr = bus.src1[31:0] + bus.imm[31:0];

    // Store data: keep the low 1/2/4/8 byte lanes, zero the rest
    logic [3:0]      store_bytes;
    logic [XLEN-1:0] store_data;

    always_comb begin
        store_bytes = 4'd0;
        case (bus.s_bhwd)
            3'd1:    store_bytes = 4'd1;
            3'd2:    store_bytes = 4'd2;
            3'd3:    store_bytes = 4'd4;
            3'd4:    store_bytes = 4'd8;
            default: store_bytes = 4'd0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_store_lane
            assign store_data[gi*8 +: 8] =
                (!bus.s_check || (4'(gi) < store_bytes)) ? b[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign bus.src2_out = store_data;

    // Branch resolution: one-hot type selects its condition; none passes the
    // decoded select through; several bits set is treated as not taken.
    logic       br_eq, br_lt, br_ltu, br_multi, br_taken;
    logic [5:0] br_cond;

    always_comb begin
        br_eq    = (bus.rs1_data == bus.rs2_data);
        br_lt    = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
        br_ltu   = (bus.rs1_data < bus.rs2_data);
        br_cond  = {~br_ltu, br_ltu, ~br_lt, br_lt, ~br_eq, br_eq};
        br_multi = |(bus.b_check & (bus.b_check - 6'd1));
        br_taken = |(bus.b_check & br_cond);
        if (bus.b_check == 6'd0)
            bus.pc_sel_out = bus.pc_sel;
        else if (br_multi || !br_taken)
            bus.pc_sel_out = 3'd0;
        else
            bus.pc_sel_out = bus.pc_sel;
    end

    // Trap/trace tracker: follow ID every cycle; reset shows a bubble marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.inst_out   <= 32'hFFFF_FFFF;
            bus.op_out     <= 12'd0;
            bus.ebreak_out <= 1'b0;
        end else begin
            bus.inst_out   <= bus.id_inst;
            bus.op_out     <= bus.id_op;
            bus.ebreak_out <= bus.id_ebreak;
        end
    end
endmodule

// File: tb/tb_exec_branch_trap_unit.sv
// Self-checking bench for exec_branch_trap_unit: directed vectors from the
// block description plus randomized ALU/store/branch/tracker stimulus checked
// against an arithmetic reference model.
module tb_exec_branch_trap_unit;
`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    exec_branch_trap_unit_if bus();

    exec_branch_trap_unit #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_alu(input logic [11:0] op, input bit w,
                                            input logic [63:0] s1, input logic [63:0] s2);
        longint          x, y, r, p64, ly;
        longint unsigned ux, uy, pu;
        int              xw, yw, rw, sh;
        int unsigned     uxw, uyw;
        logic signed [127:0] px, py, pp;
        x = s1; y = s2; ux = s1; uy = s2;
        xw = s1[31:0]; yw = s2[31:0]; uxw = s1[31:0]; uyw = s2[31:0];
        r = 0; rw = 0;
        if (op >= 13 && op <= 20 && !MULDIV) return 64'd0;
        if (w) begin
            sh = int'(s2[4:0]);
            case (op)
                1:  rw = xw + yw;
                2:  rw = xw - yw;
                3:  rw = xw << sh;
                4:  rw = (xw < yw) ? 1 : 0;
                5:  rw = (uxw < uyw) ? 1 : 0;
                6:  rw = xw ^ yw;
                7:  rw = int'(uxw >> sh);
                8:  rw = xw >>> sh;
                9:  rw = xw | yw;
                10: rw = xw & yw;
                11: rw = yw;
                12: rw = xw + 4;
                13: rw = xw * yw;
                14: begin p64 = longint'(xw) * longint'(yw); rw = p64[63:32]; end
                15: begin ly = uyw; p64 = longint'(xw) * ly; rw = p64[63:32]; end
                16: begin pu = uxw; pu = pu * uyw; rw = pu[63:32]; end
                17: rw = (yw == 0) ? -1 : ((s1[31:0] == 32'h80000000 && yw == -1) ? xw : xw / yw);
                18: rw = (uyw == 0) ? -1 : int'(uxw / uyw);
                19: rw = (yw == 0) ? xw : ((s1[31:0] == 32'h80000000 && yw == -1) ? 0 : xw % yw);
                20: rw = (uyw == 0) ? xw : int'(uxw % uyw);
                default: rw = 0;
            endcase
            r = rw;
            return r;
        end
        sh = int'(s2[5:0]);
        case (op)
            1:  r = x + y;
            2:  r = x - y;
            3:  r = x << sh;
            4:  r = (x < y) ? 1 : 0;
            5:  r = (ux < uy) ? 1 : 0;
            6:  r = x ^ y;
            7:  r = longint'(ux >> sh);
            8:  r = x >>> sh;
            9:  r = x | y;
            10: r = x & y;
            11: r = y;
            12: r = x + 4;
            13: r = x * y;
            14: begin px = x;  py = y;  pp = px * py; r = pp[127:64]; end
            15: begin px = x;  py = uy; pp = px * py; r = pp[127:64]; end
            16: begin px = ux; py = uy; pp = px * py; r = pp[127:64]; end
            17: r = (y == 0) ? -1 : ((s1 == 64'h8000000000000000 && y == -1) ? x : x / y);
            18: r = (uy == 0) ? -1 : longint'(ux / uy);
            19: r = (y == 0) ? x : ((s1 == 64'h8000000000000000 && y == -1) ? 0 : x % y);
            20: r = (uy == 0) ? x : longint'(ux % uy);
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ref_store(input bit s, input logic [2:0] size,
                                              input logic [63:0] v);
        if (!s) return v;
        case (size)
            3'd1: return v & 64'hFF;
            3'd2: return v & 64'hFFFF;
            3'd3: return v & 64'hFFFF_FFFF;
            3'd4: return v;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_branch(input logic [5:0] bc, input logic [2:0] psel,
                                              input logic [63:0] r1, input logic [63:0] r2);
        int     ones;
        bit     take;
        longint sr1, sr2;
        ones = 0;
        for (int i = 0; i < 6; i++) if (bc[i]) ones++;
        if (ones == 0) return psel;
        if (ones > 1) return 3'd0;
        sr1 = r1; sr2 = r2;
        case (bc)
            6'b000001: take = (r1 == r2);
            6'b000010: take = (r1 != r2);
            6'b000100: take = (sr1 < sr2);
            6'b001000: take = (sr1 >= sr2);
            6'b010000: take = (r1 < r2);
            default:   take = (r1 >= r2);
        endcase
        return take ? psel : 3'd0;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'h0000_0000_8000_0000;
            5: return 64'h0000_0000_7FFF_FFFF;
            6: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.op = '0; bus.w_check = 0; bus.s_check = 0; bus.s_bhwd = 0;
        bus.src1 = '0; bus.src2 = '0; bus.imm = '0;
        bus.b_check = '0; bus.pc_sel = '0; bus.rs1_data = '0; bus.rs2_data = '0;
        bus.id_inst = 32'h0000_0013; bus.id_op = 12'd1; bus.id_ebreak = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.inst_out !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_inst got %h want ffffffff", bus.inst_out);
        end
        checks++;
        if (bus.op_out !== 12'd0) begin
            errors++; $display("FAIL reset_op got %0d want 0", bus.op_out);
        end
        checks++;
        if (bus.ebreak_out !== 1'b0) begin
            errors++; $display("FAIL reset_ebreak got %b want 0", bus.ebreak_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [11:0] op;
        bit          w;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] exp;
    } alu_vec_t;

    task automatic test_alu_directed();
        alu_vec_t v[6];
        int n;
        v[0] = '{12'd1, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2};
        v[1] = '{12'd1, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
        v[2] = '{12'd8, 1'b0, 64'h8000_0000_0000_0000, 64'd68, 64'hF800_0000_0000_0000};
        v[3] = '{12'd5, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        v[4] = '{12'd17, 1'b0, 64'd7, 64'd0, MULDIV ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0};
        v[5] = '{12'd19, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        n = 6;
        for (int i = 0; i < n; i++) begin
            bus.op = v[i].op; bus.w_check = v[i].w; bus.src1 = v[i].s1; bus.src2 = v[i].s2;
            #1;
            checks++;
            if (bus.data_rd !== v[i].exp) begin
                errors++;
                $display("FAIL alu_directed[%0d] op=%0d w=%0b got %h want %h",
                         i, v[i].op, v[i].w, bus.data_rd, v[i].exp);
            end
            $display("alu_directed[%0d] op=%0d w=%0b src1=%h src2=%h data_rd=%h",
                     i, v[i].op, v[i].w, v[i].s1, v[i].s2, bus.data_rd);
        end
    endtask

    task automatic test_store_directed();
        bus.s_check = 1'b1; bus.s_bhwd = 3'd2;
        bus.src1 = 64'h8000_0100; bus.imm = 64'hFFFF_FFFF_FFFF_FFFC;
        bus.src2 = 64'h1122_3344_5566_7788;
        #1;
        checks++;
        if (bus.ram_raddr !== 32'h8000_00FC) begin
            errors++; $display("FAIL store_addr got %h want 800000fc", bus.ram_raddr);
        end
        checks++;
        if (bus.src2_out !== 64'h7788) begin
            errors++; $display("FAIL store_data got %h want 7788", bus.src2_out);
        end
        $display("store_directed addr=%h data=%h", bus.ram_raddr, bus.src2_out);
        bus.s_check = 1'b0;
    endtask

    task automatic test_branch_directed();
        logic [5:0] bc[4];
        logic [2:0] ps[4];
        logic [2:0] ex[4];
        bc[0] = 6'b000100; ps[0] = 3'd1; ex[0] = 3'd1;
        bc[1] = 6'b010000; ps[1] = 3'd1; ex[1] = 3'd0;
        bc[2] = 6'b000000; ps[2] = 3'd2; ex[2] = 3'd2;
        bc[3] = 6'b000011; ps[3] = 3'd1; ex[3] = 3'd0;
        bus.rs1_data = '1; bus.rs2_data = '0;
        for (int i = 0; i < 4; i++) begin
            bus.b_check = bc[i]; bus.pc_sel = ps[i];
            #1;
            checks++;
            if (bus.pc_sel_out !== ex[i]) begin
                errors++;
                $display("FAIL branch_directed[%0d] b_check=%b got %0d want %0d",
                         i, bc[i], bus.pc_sel_out, ex[i]);
            end
            $display("branch_directed[%0d] b_check=%b pc_sel=%0d out=%0d",
                     i, bc[i], ps[i], bus.pc_sel_out);
        end
    endtask

    task automatic test_alu_random();
        logic [63:0] exp_rd, exp_st;
        logic [31:0] exp_addr;
        for (int i = 0; i < 300; i++) begin
            bus.op      = ($urandom_range(0, 15) == 0) ? 12'($urandom) : 12'($urandom_range(0, 22));
            bus.w_check = $urandom_range(0, 1);
            bus.src1    = pick_operand();
            bus.src2    = pick_operand();
            bus.imm     = pick_operand();
            bus.s_check = $urandom_range(0, 1);
            bus.s_bhwd  = 3'($urandom_range(0, 7));
            #1;
            exp_rd   = ref_alu(bus.op, bus.w_check, bus.src1, bus.src2);
            exp_addr = 32'(bus.src1 + bus.imm);
            exp_st   = ref_store(bus.s_check, bus.s_bhwd, bus.src2);
            checks++;
            if (bus.data_rd !== exp_rd) begin
                errors++;
                $display("FAIL alu_random op=%0d w=%0b src1=%h src2=%h got %h want %h",
                         bus.op, bus.w_check, bus.src1, bus.src2, bus.data_rd, exp_rd);
            end
            checks++;
            if (bus.ram_raddr !== exp_addr) begin
                errors++;
                $display("FAIL addr_random got %h want %h", bus.ram_raddr, exp_addr);
            end
            checks++;
            if (bus.src2_out !== exp_st) begin
                errors++;
                $display("FAIL store_random s=%0b size=%0d got %h want %h",
                         bus.s_check, bus.s_bhwd, bus.src2_out, exp_st);
            end
            $display("alu_random[%0d] op=%0d w=%0b data_rd=%h addr=%h st=%h",
                     i, bus.op, bus.w_check, bus.data_rd, bus.ram_raddr, bus.src2_out);
        end
    endtask

    task automatic test_branch_random();
        logic [2:0] exp_sel;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0:       bus.b_check = 6'd0;
                1:       bus.b_check = 6'($urandom);
                default: bus.b_check = 6'(1 << $urandom_range(0, 5));
            endcase
            bus.pc_sel   = 3'($urandom_range(0, 3));
            bus.rs1_data = pick_operand();
            bus.rs2_data = ($urandom_range(0, 3) == 0) ? bus.rs1_data : pick_operand();
            #1;
            exp_sel = ref_branch(bus.b_check, bus.pc_sel, bus.rs1_data, bus.rs2_data);
            checks++;
            if (bus.pc_sel_out !== exp_sel) begin
                errors++;
                $display("FAIL branch_random b_check=%b rs1=%h rs2=%h got %0d want %0d",
                         bus.b_check, bus.rs1_data, bus.rs2_data, bus.pc_sel_out, exp_sel);
            end
            $display("branch_random[%0d] b_check=%b pc_sel=%0d out=%0d",
                     i, bus.b_check, bus.pc_sel, bus.pc_sel_out);
        end
    endtask

    task automatic test_tracker();
        @(negedge clk);
        bus.id_inst = 32'h1234_5678; bus.id_op = 12'd3; bus.id_ebreak = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.inst_out !== 32'h1234_5678) begin
            errors++; $display("FAIL tracker_capture got %h want 12345678", bus.inst_out);
        end
        // Reset asserted mid-cycle takes effect without a clock edge
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.inst_out !== 32'hFFFF_FFFF || bus.op_out !== 12'd0 || bus.ebreak_out !== 1'b0) begin
            errors++;
            $display("FAIL tracker_async_reset got %h/%0d/%b want ffffffff/0/0",
                     bus.inst_out, bus.op_out, bus.ebreak_out);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.id_inst = 32'h0010_0073; bus.id_op = 12'd7; bus.id_ebreak = 1'b1;
        #1;
        checks++;
        if (bus.inst_out !== 32'hFFFF_FFFF || bus.ebreak_out !== 1'b0) begin
            errors++;
            $display("FAIL tracker_before_edge got %h/%b want ffffffff/0",
                     bus.inst_out, bus.ebreak_out);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.inst_out !== 32'h0010_0073 || bus.op_out !== 12'd7 || bus.ebreak_out !== 1'b1) begin
            errors++;
            $display("FAIL tracker_ebreak got %h/%0d/%b want 00100073/7/1",
                     bus.inst_out, bus.op_out, bus.ebreak_out);
        end
        $display("tracker inst=%h op=%0d ebreak=%b", bus.inst_out, bus.op_out, bus.ebreak_out);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_inst;
        logic [11:0] exp_op;
        logic        exp_eb;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            exp_inst = $urandom; exp_op = 12'($urandom); exp_eb = 1'($urandom);
            bus.id_inst = exp_inst; bus.id_op = exp_op; bus.id_ebreak = exp_eb;
            @(posedge clk); #1;
            checks++;
            if (bus.inst_out !== exp_inst || bus.op_out !== exp_op || bus.ebreak_out !== exp_eb) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %h/%0d/%b want %h/%0d/%b", i,
                         bus.inst_out, bus.op_out, bus.ebreak_out, exp_inst, exp_op, exp_eb);
            end
            $display("back_to_back[%0d] inst=%h op=%0d ebreak=%b",
                     i, bus.inst_out, bus.op_out, bus.ebreak_out);
        end
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_store_directed();
        test_branch_directed();
        test_alu_random();
        test_branch_random();
        test_tracker();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
